// File: rtl/rv_test_pkg.sv
// Shared types and RISC-V encodings for the test-termination monitor.
package rv_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [6:0]  OPC_SYSTEM     = 7'b1110011;
  localparam logic [2:0]  FUNCT3_PRIV    = 3'b000;
  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

  // True when the opcode/funct3/funct12 fields encode the given privileged SYSTEM op.
  function automatic logic is_priv_op(input logic [6:0]  opcode,
                                      input logic [2:0]  funct3,
                                      input logic [11:0] funct12,
                                      input logic [11:0] target);
    return (opcode == OPC_SYSTEM) && (funct3 == FUNCT3_PRIV) && (funct12 == target);
  endfunction

endpackage

// File: rtl/rv_term_decode.sv
// Combinational decode of the two run-terminating events: an ECALL/EBREAK
// retiring, and a store of an odd word to the tohost MMIO address.
module rv_term_decode
  import rv_test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter bit          EN_ECALL    = 1'b1,
  parameter bit          EN_EBREAK   = 1'b1,
  parameter bit          EN_TOHOST   = 1'b1
) (
  input  logic        i_inst_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_funct12,
  input  logic        i_st_valid,
  input  logic [31:0] i_st_addr,
  input  logic        i_st_data_lsb,
  output logic        o_is_trap,
  output logic        o_is_tohost
);

  logic w_ecall;
  logic w_ebreak;

  assign w_ecall  = EN_ECALL  && is_priv_op(i_opcode, i_funct3, i_funct12, FUNCT12_ECALL);
  assign w_ebreak = EN_EBREAK && is_priv_op(i_opcode, i_funct3, i_funct12, FUNCT12_EBREAK);

  assign o_is_trap   = i_inst_valid && (w_ecall || w_ebreak);
  // An even tohost word is not a completion code, so only bit 0 = 1 counts.
  assign o_is_tohost = EN_TOHOST && i_st_valid && (i_st_addr == TOHOST_ADDR) && i_st_data_lsb;

endmodule

// File: rtl/rv_test_monitor.sv
// Watches a core running a riscv-tests style program and reports pass/fail,
// the failing test number, a timeout, and cycle/retire statistics.
//
// Control semantics: start and clr are level-sampled on each rising edge with
// no handshake; start only matters in IDLE, clr wins over everything in every
// state. Result outputs are sticky from entry into DONE until clr or reset.
module rv_test_monitor
  import rv_test_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          CNT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter bit          EN_ECALL       = 1'b1,
  parameter bit          EN_EBREAK      = 1'b1,
  parameter bit          EN_TOHOST      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clr,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   gp_value,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [XLEN-1:0]   st_data,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [XLEN-2:0]   fail_test,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            r_state;
  state_e            w_next_state;
  logic              r_done;
  logic              r_pass;
  logic              r_timed_out;
  logic [XLEN-2:0]   r_fail_test;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_retire_count;

  logic              w_is_trap;
  logic              w_is_tohost;
  logic              w_timeout_hit;
  logic              w_load;
  logic              w_load_pass;
  logic              w_load_timed_out;
  logic [XLEN-2:0]   w_load_fail;
  logic              w_unused_inst_bits;

  // rd/rs1 fields of ECALL/EBREAK carry no meaning for termination.
  assign w_unused_inst_bits = &{1'b0, inst[19:15], inst[11:7]};

  rv_term_decode #(
    .TOHOST_ADDR (TOHOST_ADDR),
    .EN_ECALL    (EN_ECALL),
    .EN_EBREAK   (EN_EBREAK),
    .EN_TOHOST   (EN_TOHOST)
  ) u_decode (
    .i_inst_valid  (inst_valid),
    .i_opcode      (inst[6:0]),
    .i_funct3      (inst[14:12]),
    .i_funct12     (inst[31:20]),
    .i_st_valid    (st_valid),
    .i_st_addr     (st_addr),
    .i_st_data_lsb (st_data[0]),
    .o_is_trap     (w_is_trap),
    .o_is_tohost   (w_is_tohost)
  );

  // Compared at 64 bits so a narrow counter never aliases a large timeout.
  assign w_timeout_hit = (64'(r_cycle_count) == (64'(TIMEOUT_CYCLES) - 64'd1));

  // State register; reset discards any run in flight, including a pending gp sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and the result to latch on entry into DONE.
  always_comb begin
    w_next_state     = r_state;
    w_load           = 1'b0;
    w_load_pass      = 1'b0;
    w_load_timed_out = 1'b0;
    w_load_fail      = '0;
    if (clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_next_state = ST_RUN;
        end
        ST_RUN: begin
          if (w_is_tohost) begin
            w_next_state = ST_DONE;
            w_load       = 1'b1;
            w_load_pass  = (st_data == XLEN'(1));
            w_load_fail  = (st_data == XLEN'(1)) ? '0 : st_data[XLEN-1:1];
          end else if (w_is_trap) begin
            // gp is written by the instruction before the trap; wait one cycle.
            w_next_state = ST_SETTLE;
          end else if (w_timeout_hit) begin
            w_next_state     = ST_DONE;
            w_load           = 1'b1;
            w_load_timed_out = 1'b1;
          end
        end
        ST_SETTLE: begin
          w_next_state = ST_DONE;
          w_load       = 1'b1;
          w_load_pass  = (gp_value == XLEN'(1));
          w_load_fail  = (gp_value == XLEN'(1)) ? '0 : gp_value[XLEN-1:1];
        end
        ST_DONE: begin
          w_next_state = ST_DONE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating cycle and retire counters, cleared by clr and frozen outside RUN/SETTLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else if (clr) begin
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      if ((r_state == ST_RUN || r_state == ST_SETTLE) && (r_cycle_count != CNT_MAX))
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      if ((r_state == ST_RUN) && inst_valid && (r_retire_count != CNT_MAX))
        r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  // Sticky result registers, loaded once on entry into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_test <= '0;
    end else if (clr) begin
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_fail_test <= '0;
    end else if (w_load) begin
      r_done      <= 1'b1;
      r_pass      <= w_load_pass;
      r_timed_out <= w_load_timed_out;
      r_fail_test <= w_load_fail;
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign timed_out    = r_timed_out;
  assign fail_test    = r_fail_test;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed-plus-random bench for rv_test_monitor; four builds share one stimulus
// stream (default, short timeout, ECALL disabled, 4-bit counters).
module tb_rv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, clr, inst_valid, st_valid;
  logic [31:0] inst, gp_value, st_addr, st_data;

  logic        a_done, a_pass, a_to;  logic [30:0] a_fail; logic [31:0] a_cyc, a_ret;
  logic        t_done, t_pass, t_to;  logic [30:0] t_fail; logic [31:0] t_cyc, t_ret;
  logic        e_done, e_pass, e_to;  logic [30:0] e_fail; logic [31:0] e_cyc, e_ret;
  logic        s_done, s_pass, s_to;  logic [30:0] s_fail; logic [3:0]  s_cyc, s_ret;

  int total = 0;
  int bad   = 0;

  rv_test_monitor dut_a (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .inst_valid(inst_valid), .inst(inst),
    .gp_value(gp_value), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .done(a_done), .pass(a_pass), .timed_out(a_to), .fail_test(a_fail),
    .cycle_count(a_cyc), .retire_count(a_ret));

  rv_test_monitor #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .inst_valid(inst_valid), .inst(inst),
    .gp_value(gp_value), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .done(t_done), .pass(t_pass), .timed_out(t_to), .fail_test(t_fail),
    .cycle_count(t_cyc), .retire_count(t_ret));

  rv_test_monitor #(.EN_ECALL(1'b0)) dut_e (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .inst_valid(inst_valid), .inst(inst),
    .gp_value(gp_value), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .done(e_done), .pass(e_pass), .timed_out(e_to), .fail_test(e_fail),
    .cycle_count(e_cyc), .retire_count(e_ret));

  rv_test_monitor #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .inst_valid(inst_valid), .inst(inst),
    .gp_value(gp_value), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .done(s_done), .pass(s_pass), .timed_out(s_to), .fail_test(s_fail),
    .cycle_count(s_cyc), .retire_count(s_ret));

  // ---------------- reference rules ----------------
  // Completion-code rule shared by gp and tohost: 1 is pass, otherwise code>>1.
  function automatic logic exp_pass(input logic [31:0] code);
    return (code == 32'd1);
  endfunction

  function automatic logic [30:0] exp_fail(input logic [31:0] code);
    logic [31:0] sh;
    sh = code >> 1;
    return (code == 32'd1) ? 31'd0 : sh[30:0];
  endfunction

  function automatic logic [31:0] sys_word(input logic [11:0] f12);
    logic [31:0] r;
    r = $urandom();
    return {f12, r[19:15], 3'b000, r[11:7], 7'b1110011};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic ed, input logic ep, input logic et,
                         input logic [30:0] ef, input logic [31:0] ec, input logic [31:0] er);
    check({tag, "_done"}, 64'(a_done), 64'(ed));
    check({tag, "_pass"}, 64'(a_pass), 64'(ep));
    check({tag, "_to"},   64'(a_to),   64'(et));
    check({tag, "_fail"}, 64'(a_fail), 64'(ef));
    check({tag, "_cyc"},  64'(a_cyc),  64'(ec));
    check({tag, "_ret"},  64'(a_ret),  64'(er));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b0; clr = 1'b0; inst_valid = 1'b0; inst = 32'h0000_0013;
    st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
  endtask

  // Non-terminating traffic: ALU ops, stores elsewhere, even tohost words.
  task automatic drive_filler(input bit force_valid, output int v);
    logic [31:0] r1, r2, r3;
    r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
    start = 1'b0; clr = 1'b0;
    inst_valid = force_valid ? 1'b1 : r1[0];
    inst       = {r2[31:7], 7'b0110011};
    st_valid   = r1[1];
    st_addr    = r1[2] ? TOHOST : (32'h0000_2000 + {16'h0, r3[15:2], 2'b00});
    st_data    = r1[2] ? {r3[31:1], 1'b0} : r3;
    v          = inst_valid ? 1 : 0;
  endtask

  // start pulse, then n filler cycles in RUN; nv = retires among them.
  task automatic run_fill(input int n, output int nv);
    int v;
    drive_idle();
    start = 1'b1;
    tick();
    nv = 0;
    for (int i = 0; i < n; i++) begin
      drive_filler(1'b0, v);
      nv += v;
      tick();
    end
  endtask

  task automatic do_clr();
    drive_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nv, v, n, m, mv;
    logic [31:0] g, d;

    drive_idle();
    gp_value = 32'h0;
    reset = 1'b1;
    tick(); tick();
    check_a("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // IDLE ignores traps and tohost stores.
    inst_valid = 1'b1; inst = sys_word(12'h000); gp_value = 32'd1;
    st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd1;
    tick(); tick();
    check_a("idle_ignore", 0, 0, 0, 0, 0, 0);

    // ECALL on the 20th RUN cycle, gp=1 only valid in SETTLE.
    run_fill(19, nv);
    inst_valid = 1'b1; inst = sys_word(12'h000); st_valid = 1'b0;
    gp_value = $urandom() | 32'd2;
    tick();
    check("t1_settle_done", 64'(a_done), 64'd0);
    drive_filler(1'b1, v);
    st_valid = 1'b0;
    gp_value = 32'd1;
    tick();
    check_a("t1", 1, 1, 0, 0, 32'd21, 32'(nv + 1));
    check("t1_ecall_disabled", 64'(e_done), 64'd0);
    // DONE is sticky against events and start.
    for (int i = 0; i < 3; i++) begin
      inst_valid = 1'b1; inst = sys_word(12'h001); gp_value = $urandom();
      st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd7; start = 1'b1;
      tick();
    end
    check_a("t1_hold", 1, 1, 0, 0, 32'd21, 32'(nv + 1));
    do_clr();
    check_a("t1_clr", 0, 0, 0, 0, 0, 0);

    // EBREAK with random gp; first fixed at 7, second at 0.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 30);
      run_fill(n, nv);
      inst_valid = 1'b1; inst = sys_word(12'h001); st_valid = 1'b0;
      gp_value = $urandom();
      tick();
      g = (k == 0) ? 32'd7 : (k == 1) ? 32'd0 : (k == 2) ? 32'd1 : $urandom();
      drive_idle();
      gp_value = g;
      tick();
      check_a($sformatf("ebreak%0d", k), 1, exp_pass(g), 0, exp_fail(g), 32'(n + 2), 32'(nv + 1));
      do_clr();
    end

    // tohost in the same cycle as ECALL wins.
    n = $urandom_range(1, 12);
    run_fill(n, nv);
    inst_valid = 1'b1; inst = sys_word(12'h000); gp_value = 32'd1;
    st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd5;
    tick();
    check_a("tohost_prio", 1, 0, 0, 31'd2, 32'(n + 1), 32'(nv + 1));
    drive_idle(); gp_value = 32'd1;
    tick();
    check_a("tohost_hold", 1, 0, 0, 31'd2, 32'(n + 1), 32'(nv + 1));
    do_clr();

    // Even tohost word and odd word elsewhere are ignored; odd tohost ends the run.
    run_fill(5, nv);
    drive_idle(); st_valid = 1'b1; st_addr = TOHOST; st_data = 32'd4;
    tick();
    check("even_tohost", 64'(a_done), 64'd0);
    st_addr = TOHOST + 32'd4; st_data = 32'd1;
    tick();
    check("other_addr", 64'(a_done), 64'd0);
    inst_valid = 1'b1; inst = 32'h0000_0033; st_addr = TOHOST; st_data = 32'd1;
    tick();
    check_a("tohost_pass", 1, 1, 0, 0, 32'd8, 32'(nv + 1));
    do_clr();

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(0, 20);
      run_fill(n, nv);
      d = $urandom() | 32'd1;
      drive_idle(); st_valid = 1'b1; st_addr = TOHOST; st_data = d;
      tick();
      check_a($sformatf("tohost%0d", k), 1, exp_pass(d), 0, exp_fail(d), 32'(n + 1), 32'(nv));
      do_clr();
    end

    // Timeout build: 16 RUN cycles with no terminating event.
    run_fill(15, nv);
    check("to_early_done", 64'(t_done), 64'd0);
    check("to_early_cyc", 64'(t_cyc), 64'd15);
    drive_filler(1'b0, v);
    nv += v;
    tick();
    check("to_done", 64'(t_done), 64'd1);
    check("to_flag", 64'(t_to), 64'd1);
    check("to_pass", 64'(t_pass), 64'd0);
    check("to_fail", 64'(t_fail), 64'd0);
    check("to_cyc", 64'(t_cyc), 64'd16);
    check("to_ret", 64'(t_ret), 64'(nv));
    inst_valid = 1'b1; inst = sys_word(12'h000); st_valid = 1'b0; gp_value = 32'd1;
    tick(); tick();
    check("to_after_pass", 64'(t_pass), 64'd0);
    check("to_after_to", 64'(t_to), 64'd1);
    check("to_after_cyc", 64'(t_cyc), 64'd16);
    do_clr();

    // 4-bit counters saturate at 15.
    drive_idle(); start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      drive_filler(1'b1, v);
      tick();
    end
    check("sat_cyc", 64'(s_cyc), 64'd15);
    check("sat_ret", 64'(s_ret), 64'd15);
    check("sat_done", 64'(s_done), 64'd0);
    inst_valid = 1'b1; inst = sys_word(12'h000); st_valid = 1'b0;
    tick();
    drive_idle(); gp_value = 32'd1;
    tick();
    check("sat_end_done", 64'(s_done), 64'd1);
    check("sat_end_pass", 64'(s_pass), 64'd1);
    check("sat_end_cyc", 64'(s_cyc), 64'd15);
    do_clr();

    // Reset pulse during SETTLE clears everything without a clock edge.
    run_fill(6, nv);
    inst_valid = 1'b1; inst = sys_word(12'h000); st_valid = 1'b0;
    tick();
    drive_idle(); gp_value = 32'd1;
    #2 reset = 1'b1;
    #1 check_a("async_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); tick(); tick();
    check_a("no_done_after_reset", 0, 0, 0, 0, 0, 0);
    run_fill(3, nv);
    inst_valid = 1'b1; inst = sys_word(12'h001);
    tick();
    drive_idle(); gp_value = 32'd1;
    tick();
    check_a("restart", 1, 1, 0, 0, 32'd5, 32'(nv + 1));
    do_clr();
    check_a("restart_clr", 0, 0, 0, 0, 0, 0);

    // ECALL-disabled build ignores ECALL, terminates on EBREAK.
    n = $urandom_range(0, 10);
    run_fill(n, nv);
    inst_valid = 1'b1; inst = sys_word(12'h000); st_valid = 1'b0; gp_value = 32'd1;
    tick();
    m = $urandom_range(1, 8);
    mv = 0;
    for (int i = 0; i < m; i++) begin
      drive_filler(1'b0, v);
      mv += v;
      tick();
    end
    check("noecall_done", 64'(e_done), 64'd0);
    inst_valid = 1'b1; inst = sys_word(12'h001); st_valid = 1'b0;
    tick();
    drive_idle(); gp_value = 32'd9;
    tick();
    check("noecall_e_done", 64'(e_done), 64'd1);
    check("noecall_e_pass", 64'(e_pass), 64'd0);
    check("noecall_e_fail", 64'(e_fail), 64'd4);
    check("noecall_e_cyc", 64'(e_cyc), 64'(n + m + 3));
    check("noecall_e_ret", 64'(e_ret), 64'(nv + mv + 2));
    do_clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
